// File: rtl/delta_encoder_pkg.sv
// Shared types for the delta encoder: encoder state and the FIFO entry layout.
package delta_encoder_pkg;

    typedef enum logic {
        KEY   = 1'b0,
        DELTA = 1'b1
    } enc_state_e;

    localparam int unsigned EntryValueBits = 32;

    // Widest entry form; the encoder stores only the low Data_bits+1 value bits.
    typedef struct packed {
        logic                              keyframe;
        logic signed [EntryValueBits-1:0]  value;
    } fifo_entry_t;

endpackage

// File: rtl/sample_fifo.sv
// Synchronous FIFO with occupancy count; simultaneous push and pop allowed when full.
module sample_fifo #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push,
    input  logic [Width-1:0]           push_data,
    input  logic                       pop,
    output logic [Width-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(Depth):0]     level
);

    localparam int unsigned AddrBits  = $clog2(Depth);
    localparam int unsigned LevelBits = AddrBits + 1;
    localparam logic [LevelBits-1:0] LevelFull = LevelBits'(Depth);

    logic [Width-1:0]     mem [Depth];
    logic [AddrBits-1:0]  wr_ptr_q;
    logic [AddrBits-1:0]  rd_ptr_q;
    logic [LevelBits-1:0] level_q;
    logic                 do_push;
    logic                 do_pop;

    assign empty    = (level_q == '0);
    assign full     = (level_q == LevelFull);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr_q];
    assign level    = level_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i && do_push) mem[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/delta_encoder.sv
// Frame-based delta encoder: keyframe raw sample, then exact deltas, into an output FIFO.
module delta_encoder
    import delta_encoder_pkg::*;
#(
    parameter int unsigned Data_bits  = 10,
    parameter int unsigned Frame_len  = 256,
    parameter int unsigned Fifo_depth = 4
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [Data_bits-1:0]            data_in,
    input  logic                            data_valid_i,
    output logic [Data_bits:0]              data_out,
    output logic                            data_valid_o,
    input  logic                            data_ready_i,
    output logic                            keyframe_o,
    output logic                            overflow_o,
    output logic [$clog2(Fifo_depth):0]     fifo_level_o
);

    localparam int unsigned OutBits   = Data_bits + 1;
    localparam int unsigned EntryBits = Data_bits + 2;
    localparam int unsigned LevelBits = $clog2(Fifo_depth) + 1;
    localparam int unsigned CntBits   = $clog2(Frame_len + 1);
    localparam logic [CntBits-1:0] FrameLast = CntBits'(Frame_len);
    localparam logic [CntBits-1:0] CntFirst  = CntBits'(1);

    enc_state_e             state_q;
    logic [CntBits-1:0]     frame_cnt_q;
    logic [CntBits-1:0]     frame_cnt_inc;
    logic [Data_bits-1:0]   prev_q;
    logic                   overflow_q;

    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   pop;
    logic                   accept;
    logic                   drop;
    logic [OutBits-1:0]     raw_ext;
    logic [OutBits-1:0]     delta;
    logic [EntryBits-1:0]   push_entry;
    logic [EntryBits-1:0]   head_entry;
    logic [LevelBits-1:0]   level;

    assign pop    = !fifo_empty && data_ready_i;
    assign accept = data_valid_i && (!fifo_full || pop);
    assign drop   = data_valid_i && fifo_full && !pop;

    // One extra bit makes the difference of two Data_bits values exact.
    assign raw_ext       = {data_in[Data_bits-1], data_in};
    assign delta         = raw_ext - {prev_q[Data_bits-1], prev_q};
    assign frame_cnt_inc = frame_cnt_q + 1'b1;

    always_comb begin
        push_entry = '0;
        if (state_q == KEY) push_entry = {1'b1, raw_ext};
        else                push_entry = {1'b0, delta};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= KEY;
            frame_cnt_q <= '0;
            prev_q      <= '0;
            overflow_q  <= 1'b0;
        end else if (accept) begin
            prev_q <= data_in;
            if (state_q == KEY) begin
                frame_cnt_q <= CntFirst;
                state_q     <= (CntFirst == FrameLast) ? KEY : DELTA;
            end else begin
                frame_cnt_q <= frame_cnt_inc;
                state_q     <= (frame_cnt_inc == FrameLast) ? KEY : DELTA;
            end
        end else if (drop) begin
            // A lost sample breaks the delta chain; restart with a keyframe.
            overflow_q  <= 1'b1;
            state_q     <= KEY;
            frame_cnt_q <= '0;
        end
    end

    sample_fifo #(
        .Width (EntryBits),
        .Depth (Fifo_depth)
    ) u_fifo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .push      (accept),
        .push_data (push_entry),
        .pop       (pop),
        .pop_data  (head_entry),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (level)
    );

    assign data_valid_o = !fifo_empty;
    assign data_out     = fifo_empty ? '0 : head_entry[OutBits-1:0];
    assign keyframe_o   = !fifo_empty && head_entry[EntryBits-1];
    assign overflow_o   = overflow_q;
    assign fifo_level_o = level;

endmodule

// File: tb/tb_delta_encoder.sv
// Directed self-checking bench for delta_encoder (Frame_len=4, Fifo_depth=4, Data_bits=10).
module tb_delta_encoder;
    import delta_encoder_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [9:0]  data_in = '0;
    logic        data_valid_i = 1'b0;
    logic [10:0] data_out;
    logic        data_valid_o;
    logic        data_ready_i = 1'b0;
    logic        keyframe_o;
    logic        overflow_o;
    logic [2:0]  fifo_level_o;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    delta_encoder #(
        .Data_bits  (10),
        .Frame_len  (4),
        .Fifo_depth (4)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .data_in      (data_in),
        .data_valid_i (data_valid_i),
        .data_out     (data_out),
        .data_valid_o (data_valid_o),
        .data_ready_i (data_ready_i),
        .keyframe_o   (keyframe_o),
        .overflow_o   (overflow_o),
        .fifo_level_o (fifo_level_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic signed [31:0] got,
                            input logic signed [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic expect_head(input string tag, input fifo_entry_t e);
        check_eq({tag, ".valid"}, 32'(data_valid_o), 1);
        check_eq({tag, ".key"},   32'(keyframe_o), 32'(e.keyframe));
        check_eq({tag, ".data"},  32'($signed(data_out)), e.value);
    endtask

    task automatic expect_empty(input string tag);
        check_eq({tag, ".valid"}, 32'(data_valid_o), 0);
        check_eq({tag, ".level"}, 32'(fifo_level_o), 0);
        check_eq({tag, ".data"},  32'(data_out), 0);
        check_eq({tag, ".key"},   32'(keyframe_o), 0);
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        data_valid_i = 1'b0;
        step();
        rst_i = 1'b0;
    endtask

    task automatic send(input int v);
        data_in = 10'(v);
        data_valid_i = 1'b1;
        step();
    endtask

    initial begin
        // Reset state
        data_ready_i = 1'b1;
        step();
        step();
        rst_i = 1'b0;
        expect_empty("rst");
        check_eq("rst.ovf", 32'(overflow_o), 0);

        // Basic keyframe + deltas, one cycle latency
        send(100);
        expect_head("basic0", '{keyframe: 1'b1, value: 100});
        check_eq("basic0.level", 32'(fifo_level_o), 1);
        send(103);
        expect_head("basic1", '{keyframe: 1'b0, value: 3});
        send(98);
        expect_head("basic2", '{keyframe: 1'b0, value: -5});
        data_valid_i = 1'b0;
        step();
        check_eq("basic.drain", 32'(data_valid_o), 0);

        // Full-range delta without saturation
        do_reset();
        send(-512);
        expect_head("range0", '{keyframe: 1'b1, value: -512});
        send(511);
        expect_head("range1", '{keyframe: 1'b0, value: 1023});
        data_valid_i = 1'b0;
        step();

        // Frame boundaries: keyframes on entries 1, 5, 9
        do_reset();
        for (int i = 0; i < 9; i++) begin
            send((i + 1) * 10);
            if (i == 0 || i == 4 || i == 8)
                expect_head($sformatf("frame%0d", i), '{keyframe: 1'b1, value: (i + 1) * 10});
            else
                expect_head($sformatf("frame%0d", i), '{keyframe: 1'b0, value: 10});
        end
        data_valid_i = 1'b0;
        step();

        // Fill, hold, full push+pop, overflow, resync
        do_reset();
        data_ready_i = 1'b0;
        send(5);
        check_eq("fill.l1", 32'(fifo_level_o), 1);
        send(7);
        check_eq("fill.l2", 32'(fifo_level_o), 2);
        send(2);
        check_eq("fill.l3", 32'(fifo_level_o), 3);
        send(9);
        check_eq("fill.l4", 32'(fifo_level_o), 4);
        data_valid_i = 1'b0;
        step();
        step();
        expect_head("hold", '{keyframe: 1'b1, value: 5});
        data_ready_i = 1'b1;
        send(20);
        check_eq("fullpp.level", 32'(fifo_level_o), 4);
        check_eq("fullpp.ovf", 32'(overflow_o), 0);
        expect_head("fullpp", '{keyframe: 1'b0, value: 2});
        data_ready_i = 1'b0;
        send(30);
        check_eq("drop0.level", 32'(fifo_level_o), 4);
        check_eq("drop0.ovf", 32'(overflow_o), 1);
        send(40);
        check_eq("drop1.level", 32'(fifo_level_o), 4);
        expect_head("drop1", '{keyframe: 1'b0, value: 2});
        data_valid_i = 1'b0;
        data_ready_i = 1'b1;
        step();
        expect_head("drain1", '{keyframe: 1'b0, value: -5});
        step();
        expect_head("drain2", '{keyframe: 1'b0, value: 7});
        step();
        expect_head("drain3", '{keyframe: 1'b1, value: 20});
        step();
        check_eq("drain.empty", 32'(data_valid_o), 0);
        send(50);
        expect_head("resync", '{keyframe: 1'b1, value: 50});
        check_eq("resync.ovf", 32'(overflow_o), 1);
        data_valid_i = 1'b0;
        step();

        // Reset with buffered entries; input during reset is ignored
        do_reset();
        data_ready_i = 1'b0;
        send(1);
        send(2);
        send(3);
        check_eq("midrst.l3", 32'(fifo_level_o), 3);
        rst_i = 1'b1;
        data_in = 10'd77;
        data_valid_i = 1'b1;
        step();
        expect_empty("midrst");
        check_eq("midrst.ovf", 32'(overflow_o), 0);
        rst_i = 1'b0;
        data_ready_i = 1'b1;
        send(8);
        expect_head("postrst", '{keyframe: 1'b1, value: 8});
        data_valid_i = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/delta_encoder.md
DELTA_ENCODER -- requirements
Module: delta_encoder

Interface
REQ-001 Parameter Data_bits, default 10, width of incoming filtered samples (two's complement).
REQ-002 Parameter Frame_len, default 256, accepted samples per frame; first sample of each frame is sent raw as keyframe.
REQ-003 Parameter Fifo_depth, default 4, output buffer entries; power of two, >= 2.
REQ-004 clk_i  input  1  single clock; all logic on rising edge.
REQ-005 rst_i  input  1  synchronous, active-high reset.
REQ-006 data_in  input  Data_bits  filtered sample from upstream high-pass filter.
REQ-007 data_valid_i  input  1  one-cycle strobe; data_in valid this cycle; no ready toward upstream.
REQ-008 data_out  output  Data_bits+1  FIFO head: raw keyframe sample (sign-extended) or delta.
REQ-009 data_valid_o  output  1  FIFO non-empty.
REQ-010 data_ready_i  input  1  downstream accepts data_out when high together with data_valid_o.
REQ-011 keyframe_o  output  1  FIFO-head entry is a keyframe; qualified by data_valid_o.
REQ-012 overflow_o  output  1  sticky; set when any sample is dropped; cleared only by reset.
REQ-013 fifo_level_o  output  $clog2(Fifo_depth)+1  current FIFO occupancy.

Function
REQ-014 Encoder FSM states: KEY (next accepted sample is a keyframe), DELTA (next accepted sample is delta-coded).
REQ-015 KEY + accepted sample -> push {keyframe=1, sign-extended data_in}; frame_cnt <= 1; go DELTA.
REQ-016 DELTA + accepted sample -> push {keyframe=0, signed(data_in) - signed(prev)} computed exactly in Data_bits+1 bits, no saturation or wrap.
REQ-017 In DELTA, frame_cnt increments per accepted sample; when accepted sample makes frame_cnt == Frame_len, go KEY.
REQ-018 prev register loads data_in on every accepted sample, keyframe or delta.
REQ-019 Sample is accepted when data_valid_i=1 and FIFO not full, or FIFO full and a pop occurs in the same cycle (level unchanged).
REQ-020 Sample with data_valid_i=1, FIFO full, no pop: dropped, not pushed, prev unchanged; overflow_o <= 1; FSM forced to KEY (resync); frame_cnt <= 0.
REQ-021 Pop occurs when data_valid_o=1 and data_ready_i=1; FIFO head advances next cycle.
REQ-022 data_out/keyframe_o stable while data_valid_o=1 and data_ready_i=0.
REQ-023 Latency: sample accepted in cycle t into empty FIFO -> data_valid_o=1 with its entry in cycle t+1.
REQ-024 data_valid_i in consecutive cycles fully supported; throughput one sample per cycle when data_ready_i=1.
REQ-025 FIFO pointers wrap modulo Fifo_depth; order strictly preserved.

Reset
REQ-026 rst_i=1 on a clock edge: FSM -> KEY, frame_cnt=0, prev=0, FIFO emptied, overflow_o=0.
REQ-027 Outputs during/after reset: data_valid_o=0, keyframe_o=0, data_out=0, fifo_level_o=0.
REQ-028 Reset mid-stream discards buffered entries; first sample after reset is a keyframe.
REQ-029 data_valid_i ignored in any cycle with rst_i=1.

Structure
REQ-030 Package delta_encoder_pkg holds encoder state enum (KEY, DELTA) and FIFO entry struct {keyframe, value}.
REQ-031 One sub-module, sample_fifo: synchronous FIFO, parameterised width/depth, push/pop/full/empty/level, synchronous active-high reset.
REQ-032 Encoder FSM, frame_cnt, prev register and subtractor reside in delta_encoder.

Verification
REQ-033 Reset, data_ready_i=1, inputs 100, 103, 98 -> outputs 100 (key=1), +3, -5, one cycle after each input.
REQ-034 Data_bits=10, inputs -512 then 511 -> keyframe -512, delta +1023 in 11 bits, no saturation.
REQ-035 Frame_len=4, 9 consecutive inputs -> keyframe_o=1 on entries 1, 5, 9 only.
REQ-036 data_ready_i=0, 6 consecutive inputs, Fifo_depth=4 -> level 4, samples 5-6 dropped, overflow_o=1; next input after release is keyframe.
REQ-037 FIFO full, data_valid_i and pop same cycle -> sample accepted, level stays 4, overflow_o stays 0.
REQ-038 Reset asserted with 3 entries buffered -> next cycle data_valid_o=0, level 0; next input emitted as keyframe.
